// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake, overflow and illegal-opcode flags.
// Define ALU_MULT_EN to build the multi-cycle shift-add MULTU datapath and its MUL state.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid_i,
  output logic             inReady_o,
  input  logic [WIDTH-1:0] dataA_i,
  input  logic [WIDTH-1:0] dataB_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [3:0]       ctl_i,
  output logic             outValid_o,
  input  logic             outReady_i,
  output logic [WIDTH-1:0] dataOut_o,
  output logic [WIDTH-1:0] hiOut_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  logic             out_valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] hi_q;
  logic             ovf_q;
  logic             ill_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic             is_mul;
  logic             accept;

  assign sum    = dataA_i + dataB_i;
  assign diff   = dataA_i - dataB_i;
  assign accept = inValid_i && inReady_o;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (ctl_i)
      4'b0000: alu_res = dataA_i & dataB_i;
      4'b0001: alu_res = dataA_i | dataB_i;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (dataA_i[WIDTH-1] == dataB_i[WIDTH-1]) && (sum[WIDTH-1] != dataA_i[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (dataA_i[WIDTH-1] != dataB_i[WIDTH-1]) && (diff[WIDTH-1] != dataA_i[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA_i) < $signed(dataB_i))};
      4'b1000: alu_res = dataA_i << shamt_i;
      4'b1001: alu_res = dataA_i >> shamt_i;
      4'b1010: alu_res = $signed(dataA_i) >>> shamt_i;
      4'b1011: alu_res = ~(dataA_i | dataB_i);
`ifdef ALU_MULT_EN
      4'b1100: is_mul = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULT_EN
  localparam int CW = SHW + 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     step_sum;
  logic               mul_done;

  // Right-shifting accumulator: add into the high half, then shift the carry back in.
  assign step_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_d     = {step_sum, acc_q[WIDTH-1:1]};
  assign mul_done  = (state_q == S_MUL) && (count_q == CW'(1));
  assign inReady_o = (state_q == S_IDLE) && (!out_valid_q || outReady_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_mul) begin
            mcand_q  <= dataA_i;
            mplier_q <= dataB_i;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH);
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - 1'b1;
          if (count_q == CW'(1)) state_q <= S_IDLE;
        end
      endcase
    end
  end
`else
  assign inReady_o = !out_valid_q || outReady_i;
`endif

  // A freshly written result takes priority over the consume of the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      hi_q        <= '0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_q <= 1'b1;
      data_q      <= alu_res;
      hi_q        <= '0;
      ovf_q       <= alu_ovf;
      ill_q       <= alu_ill;
`ifdef ALU_MULT_EN
    end else if (mul_done) begin
      out_valid_q <= 1'b1;
      data_q      <= acc_d[WIDTH-1:0];
      hi_q        <= acc_d[2*WIDTH-1:WIDTH];
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
`endif
    end else if (out_valid_q && outReady_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign outValid_o = out_valid_q;
  assign dataOut_o  = data_q;
  assign hiOut_o    = hi_q;
  assign ovf_o      = ovf_q;
  assign illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: opcodes, flags, handshake/backpressure, MULTU latency and reset abort.
module tb_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic [4:0]   shamt = '0;
  logic [3:0]   ctl = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] data_out;
  logic [W-1:0] hi_out;
  logic         ovf;
  logic         illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.WIDTH(W), .SHW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inValid_i  (in_valid),
    .inReady_o  (in_ready),
    .dataA_i    (data_a),
    .dataB_i    (data_b),
    .shamt_i    (shamt),
    .ctl_i      (ctl),
    .outValid_o (out_valid),
    .outReady_i (out_ready),
    .dataOut_o  (data_out),
    .hiOut_o    (hi_out),
    .ovf_o      (ovf),
    .illegal_o  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    ctl = c; data_a = a; data_b = b; shamt = sh;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh,
                         input logic [W-1:0] exp_d, input logic exp_ovf, input logic exp_ill);
    issue(c, a, b, sh);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, data_out, exp_d);
    chk({tag, "_hi"}, hi_out, 0);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_ill"}, illegal, exp_ill);
  endtask

`ifdef ALU_MULT_EN
  task automatic mul_chk(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int lat;
    int ready_seen;
    issue(4'b1100, a, b, 5'd0);
    lat = 0;
    ready_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_inready_busy"}, ready_seen, 0);
    chk({tag, "_hi"}, hi_out, exp_hi);
    chk({tag, "_lo"}, data_out, exp_lo);
    chk({tag, "_ill"}, illegal, 0);
    tick();
  endtask
`endif

  initial begin
    int seen;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ill", illegal, 0);
    #10 rst_n = 1'b1;
    #1 chk("rst_inready", in_ready, 1);
    tick();

    alu_chk("sub", 4'b0110, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    alu_chk("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1, 1'b0);
    alu_chk("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    alu_chk("add_neg", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    alu_chk("slt_wrap", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 32'd1, 1'b0, 1'b0);
    alu_chk("slt_ge", 4'b0111, 32'd5, 32'd3, 5'd0, 32'd0, 1'b0, 1'b0);
    alu_chk("sra", 4'b1010, 32'h8000_0000, 32'd0, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    alu_chk("srl", 4'b1001, 32'h8000_0000, 32'd0, 5'd31, 32'd1, 1'b0, 1'b0);
    alu_chk("sll", 4'b1000, 32'h0000_0001, 32'd0, 5'd4, 32'h10, 1'b0, 1'b0);
    alu_chk("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0);
    alu_chk("or", 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0);
    alu_chk("nor", 4'b1011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F, 1'b0, 1'b0);
    alu_chk("ill_f", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'd0, 1'b0, 1'b1);
    alu_chk("ill_3", 4'b0011, 32'h1234_5678, 32'h1, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    chk("drain_valid", out_valid, 0);

`ifdef ALU_MULT_EN
    mul_chk("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul_chk("mul_pow", 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000);
    mul_chk("mul_small", 32'd3, 32'd5, 32'd0, 32'd15);
`else
    issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    chk("mul_off_valid", out_valid, 1);
    chk("mul_off_ill", illegal, 1);
    chk("mul_off_data", data_out, 0);
    chk("mul_off_hi", hi_out, 0);
    tick();
`endif

    out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd2, 5'd0);
    chk("bp_first", data_out, 3);
    ctl = 4'b0010; data_a = 32'd10; data_b = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", data_out, 3);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_data", data_out, 30);
    chk("bp_next_valid", out_valid, 1);
    tick();
    chk("bp_drained", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      ctl = 4'b0010; data_a = 32'(i * 16); data_b = 32'd1000; in_valid = 1'b1;
      #1 chk("b2b_ready", in_ready, 1);
      tick();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data", data_out, 32'(1000 + i * 16));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drained", out_valid, 0);

`ifdef ALU_MULT_EN
    issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    repeat (9) tick();
`else
    out_ready = 1'b0;
    issue(4'b0001, 32'h0000_00FF, 32'd0, 5'd0);
    chk("rst_pre_data", data_out, 32'hFF);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", data_out, 0);
    chk("rst_mid_hi", hi_out, 0);
    chk("rst_mid_ill", illegal, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("rst_mid_inready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_no_result", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
